// File: rtl/sgmii_an_pkg.sv
// Shared constants for the SGMII / 1000BASE-X Clause 37 auto-negotiation
// config path: ordered-set symbols, rx parser states and config-word fields.
package sgmii_an_pkg;

    // 8b/10b symbols used by /C/ and /I/ ordered sets
    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic [7:0] D21_5  = 8'hB5;  // second symbol of /C1/
    localparam logic [7:0] D2_2   = 8'h42;  // second symbol of /C2/
    localparam logic [7:0] D5_6   = 8'hC5;  // second symbol of /I1/
    localparam logic [7:0] D16_2  = 8'h50;  // second symbol of /I2/

    // Receive parser states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COMMA  = 2'd1,
        CFG_LO = 2'd2,
        CFG_HI = 2'd3
    } rx_state_t;

    // Config-word bit fields, shared with the config transmitter
    localparam int CFG_ACK_BIT      = 14;
    localparam int CFG_NP_BIT       = 15;
    localparam int SGMII_LINK_BIT   = 15;
    localparam int SGMII_DUPLEX_BIT = 12;
    localparam int SGMII_SPEED_LSB  = 10;
    localparam int SGMII_SPEED_W    = 2;
    localparam int SGMII_SEL_BIT    = 0;

    // Second symbol of a /C1/ or /C2/ set
    function automatic logic is_cfg_code(input logic [7:0] d);
        return (d == D21_5) || (d == D2_2);
    endfunction

    // Second symbol of an /I1/ or /I2/ set
    function automatic logic is_idle_code(input logic [7:0] d);
        return (d == D5_6) || (d == D16_2);
    endfunction

endpackage

// File: rtl/sgmii_an_match_cnt.sv
// Saturating consecutive-match counter. An equal event advances the run,
// a not-equal event restarts it at one, clear drops it to zero. The match
// flag is registered and updates on the same edge as the count.
module sgmii_an_match_cnt #(
    parameter int MATCH_COUNT = 3,
    parameter int CNT_W       = 3
) (
    input  logic clk,
    input  logic srst,
    input  logic hit_eq,
    input  logic hit_ne,
    input  logic clear,
    output logic match,
    output logic match_next
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             match_reg;

    // Next count: clear wins, a mismatch restarts the run, a match extends it
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (hit_ne) begin
            count_next = CNT_W'(1);
        end else if (hit_eq && (count_reg != CNT_W'(MATCH_COUNT))) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    assign match_next = (count_next == CNT_W'(MATCH_COUNT));

    // Count and match flag registers
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
            match_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            match_reg <= match_next;
        end
    end

    assign match = match_reg;

endmodule

// File: rtl/sgmii_an_config_rx.sv
// Clause 37 receive-side ordered-set parser: finds /C1/ /C2/ /I1/ /I2/ in
// the decoded byte stream, extracts the link-partner config word and
// qualifies it with ability / acknowledge / idle match flags.
module sgmii_an_config_rx
    import sgmii_an_pkg::*;
#(
    parameter int MATCH_COUNT = 3,
    parameter int CNT_W       = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_is_k,
    input  logic        rx_code_err,
    output logic [15:0] cfg_word,
    output logic        cfg_valid,
    output logic        ability_match,
    output logic        ack_match,
    output logic        idle_match,
    output logic        config_seen,
    output logic        rx_err
);

    rx_state_t   state_reg;
    logic [7:0]  lo_byte_reg;
    logic [15:0] cfg_word_reg;
    logic        cfg_valid_reg;
    logic        config_seen_reg;
    logic        rx_err_reg;

    logic        comma_det;
    logic        cfg_start;
    logic        lo_done;
    logic        word_done;
    logic        idle_done;
    logic        abort;
    logic [15:0] new_word;
    logic [15:0] word_diff;
    logic        word_eq;
    logic        cfg_match_next;
    logic        idle_match_next;

    // Classify the accepted byte against the current parser state
    always_comb begin
        comma_det = 1'b0;
        cfg_start = 1'b0;
        lo_done   = 1'b0;
        word_done = 1'b0;
        idle_done = 1'b0;
        abort     = 1'b0;
        if (rx_valid) begin
            if (rx_code_err) begin
                abort = 1'b1;
            end else begin
                case (state_reg)
                    HUNT: begin
                        comma_det = rx_is_k && (rx_data == K28_5);
                    end
                    COMMA: begin
                        if (!rx_is_k && is_cfg_code(rx_data)) begin
                            cfg_start = 1'b1;
                        end else if (!rx_is_k && is_idle_code(rx_data)) begin
                            idle_done = 1'b1;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                    CFG_LO: begin
                        if (rx_is_k) abort = 1'b1;
                        else         lo_done = 1'b1;
                    end
                    CFG_HI: begin
                        if (rx_is_k) abort = 1'b1;
                        else         word_done = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Incoming word compared bit-by-bit with the previous one, ACK excluded
    assign new_word = {rx_data, lo_byte_reg};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cmp
            if (gi == CFG_ACK_BIT) begin : g_ack
                assign word_diff[gi] = 1'b0;
            end else begin : g_bit
                assign word_diff[gi] = new_word[gi] ^ cfg_word_reg[gi];
            end
        end
    endgenerate

    assign word_eq = ~|word_diff;

    // Parser FSM with registered word, pulses and sticky config flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= HUNT;
            lo_byte_reg     <= '0;
            cfg_word_reg    <= '0;
            cfg_valid_reg   <= 1'b0;
            config_seen_reg <= 1'b0;
            rx_err_reg      <= 1'b0;
        end else begin
            cfg_valid_reg <= word_done;
            rx_err_reg    <= abort;
            if (abort || word_done || idle_done) begin
                state_reg <= HUNT;
            end else if (comma_det) begin
                state_reg <= COMMA;
            end else if (cfg_start) begin
                state_reg <= CFG_LO;
            end else if (lo_done) begin
                state_reg   <= CFG_HI;
                lo_byte_reg <= rx_data;
            end
            if (word_done) begin
                cfg_word_reg    <= new_word;
                config_seen_reg <= 1'b1;
            end else if (idle_match_next) begin
                config_seen_reg <= 1'b0;
            end
        end
    end

    // Run of equal config words; broken by idles and errors
    sgmii_an_match_cnt #(
        .MATCH_COUNT (MATCH_COUNT),
        .CNT_W       (CNT_W)
    ) u_cfg_cnt (
        .clk        (clock),
        .srst       (reset),
        .hit_eq     (word_done & word_eq),
        .hit_ne     (word_done & ~word_eq),
        .clear      (abort | idle_done),
        .match      (ability_match),
        .match_next (cfg_match_next)
    );

    // Run of idle sets; broken by config words and errors
    sgmii_an_match_cnt #(
        .MATCH_COUNT (MATCH_COUNT),
        .CNT_W       (CNT_W)
    ) u_idle_cnt (
        .clk        (clock),
        .srst       (reset),
        .hit_eq     (idle_done),
        .hit_ne     (1'b0),
        .clear      (abort | word_done),
        .match      (idle_match),
        .match_next (idle_match_next)
    );

    assign cfg_word    = cfg_word_reg;
    assign cfg_valid   = cfg_valid_reg;
    assign config_seen = config_seen_reg;
    assign rx_err      = rx_err_reg;
    assign ack_match   = ability_match & cfg_word_reg[CFG_ACK_BIT];

endmodule

// File: tb/tb_sgmii_an_config_rx.sv
// Testbench for sgmii_an_config_rx: directed vector table, stall and
// reset corner cases, then randomized ordered-set traffic checked against
// a history-based reference model.
module tb_sgmii_an_config_rx;

    localparam int MC = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_is_k;
    logic        rx_code_err;
    logic [15:0] cfg_word;
    logic        cfg_valid;
    logic        ability_match;
    logic        ack_match;
    logic        idle_match;
    logic        config_seen;
    logic        rx_err;

    always #4 clock = ~clock;

    sgmii_an_config_rx #(.MATCH_COUNT(MC), .CNT_W(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_is_k       (rx_is_k),
        .rx_code_err   (rx_code_err),
        .cfg_word      (cfg_word),
        .cfg_valid     (cfg_valid),
        .ability_match (ability_match),
        .ack_match     (ack_match),
        .idle_match    (idle_match),
        .config_seen   (config_seen),
        .rx_err        (rx_err)
    );

    typedef enum int {OP_C1, OP_C2, OP_I1, OP_I2, OP_KLO, OP_EHI} op_t;

    typedef struct {
        op_t         op;
        logic [15:0] word;
        logic        v;
        logic [15:0] w;
        logic        ab;
        logic        ack;
        logic        idle;
        logic        seen;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    // Reference model: words seen since the last break, idle run length
    logic [15:0] hist[$];
    int          idle_n;
    logic [15:0] m_word;
    logic        m_seen;
    logic        m_v;
    logic        m_err;

    logic [15:0] pool [4] = '{16'h0001, 16'h4001, 16'h01A0, 16'h41A0};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input logic v, input logic [15:0] w,
                             input logic ab, input logic ack, input logic idle,
                             input logic seen, input logic err);
        chk({tag, ".cfg_valid"},     {15'd0, cfg_valid},     {15'd0, v});
        chk({tag, ".cfg_word"},      cfg_word,               w);
        chk({tag, ".ability_match"}, {15'd0, ability_match}, {15'd0, ab});
        chk({tag, ".ack_match"},     {15'd0, ack_match},     {15'd0, ack});
        chk({tag, ".idle_match"},    {15'd0, idle_match},    {15'd0, idle});
        chk({tag, ".config_seen"},   {15'd0, config_seen},   {15'd0, seen});
        chk({tag, ".rx_err"},        {15'd0, rx_err},        {15'd0, err});
    endtask

    // Ability holds when the last MC words agree outside the ACK bit
    function automatic logic model_ab();
        int n;
        logic [15:0] mask;
        mask = 16'hFFFF;
        mask[14] = 1'b0;
        n = hist.size();
        if (n < MC) return 1'b0;
        for (int i = 1; i < MC; i++)
            if ((hist[n-1-i] & mask) != (hist[n-1] & mask)) return 1'b0;
        return 1'b1;
    endfunction

    // One byte, optionally preceded by a stall cycle carrying junk
    task automatic put(input logic [7:0] d, input logic k, input logic e, input logic stall);
        if (stall) begin
            rx_valid    = 1'b0;
            rx_data     = 8'($urandom);
            rx_is_k     = 1'($urandom);
            rx_code_err = 1'($urandom);
            @(posedge clock); #1;
        end
        rx_valid    = 1'b1;
        rx_data     = d;
        rx_is_k     = k;
        rx_code_err = e;
        @(posedge clock); #1;
        rx_valid    = 1'b0;
        rx_code_err = 1'b0;
    endtask

    // Send one ordered set (or a broken one) and update the model
    task automatic send_op(input op_t op, input logic [15:0] w, input logic stall);
        logic [7:0] d [4];
        logic       k [4];
        logic       e [4];
        int         n;
        for (int i = 0; i < 4; i++) begin d[i] = 8'h00; k[i] = 1'b0; e[i] = 1'b0; end
        d[0] = 8'hBC; k[0] = 1'b1;
        n = 4;
        case (op)
            OP_C1:  begin d[1] = 8'hB5; d[2] = w[7:0]; d[3] = w[15:8]; end
            OP_C2:  begin d[1] = 8'h42; d[2] = w[7:0]; d[3] = w[15:8]; end
            OP_I1:  begin d[1] = 8'hC5; n = 2; end
            OP_I2:  begin d[1] = 8'h50; n = 2; end
            OP_KLO: begin d[1] = 8'hB5; d[2] = 8'hBC; k[2] = 1'b1; n = 3; end
            default: begin d[1] = 8'h42; d[2] = w[7:0]; d[3] = w[15:8]; e[3] = 1'b1; end
        endcase
        for (int i = 0; i < n; i++) begin
            put(d[i], k[i], e[i], stall);
            if (i < n - 1) begin
                chk("mid.cfg_valid", {15'd0, cfg_valid}, 16'd0);
                chk("mid.rx_err",    {15'd0, rx_err},    16'd0);
            end
        end
        m_v = 1'b0;
        m_err = 1'b0;
        case (op)
            OP_C1, OP_C2: begin
                hist.push_back(w);
                if (hist.size() > MC) void'(hist.pop_front());
                idle_n = 0;
                m_word = w;
                m_seen = 1'b1;
                m_v = 1'b1;
            end
            OP_I1, OP_I2: begin
                hist.delete();
                if (idle_n < MC) idle_n++;
                if (idle_n >= MC) m_seen = 1'b0;
            end
            default: begin
                hist.delete();
                idle_n = 0;
                m_err = 1'b1;
            end
        endcase
        $display("set %s word=%h stall=%b -> cfg_word=%h v=%b ab=%b ack=%b idle=%b seen=%b err=%b",
                 op.name(), w, stall, cfg_word, cfg_valid, ability_match, ack_match,
                 idle_match, config_seen, rx_err);
    endtask

    task automatic do_reset(input string tag);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_exp(tag, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hist.delete();
        idle_n = 0;
        m_word = 16'h0000;
        m_seen = 1'b0;
        $display("reset %s", tag);
    endtask

    task automatic add(input op_t op, input logic [15:0] word, input logic v, input logic [15:0] w,
                       input logic ab, input logic ack, input logic idle, input logic seen,
                       input logic err);
        vec_t t;
        t.op = op; t.word = word; t.v = v; t.w = w; t.ab = ab; t.ack = ack;
        t.idle = idle; t.seen = seen; t.err = err;
        tbl.push_back(t);
    endtask

    initial begin
        int          r;
        int          reps;
        op_t         op;
        logic [15:0] w;

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_is_k = 1'b0; rx_code_err = 1'b0;
        hist.delete(); idle_n = 0; m_word = 16'h0000; m_seen = 1'b0; m_v = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        do_reset("reset");

        //   op      word      v  cfg_word  ab ack idl seen err
        add(OP_C1,  16'h4001, 1, 16'h4001, 0, 0, 0, 1, 0);
        add(OP_C2,  16'h4001, 1, 16'h4001, 0, 0, 0, 1, 0);
        add(OP_C1,  16'h4001, 1, 16'h4001, 1, 1, 0, 1, 0);
        add(OP_I2,  16'h0000, 0, 16'h4001, 0, 0, 0, 1, 0);
        add(OP_I2,  16'h0000, 0, 16'h4001, 0, 0, 0, 1, 0);
        add(OP_I2,  16'h0000, 0, 16'h4001, 0, 0, 1, 0, 0);
        add(OP_C1,  16'h0001, 1, 16'h0001, 0, 0, 0, 1, 0);
        add(OP_C2,  16'h0001, 1, 16'h0001, 0, 0, 0, 1, 0);
        add(OP_C1,  16'h4001, 1, 16'h4001, 1, 1, 0, 1, 0);
        add(OP_KLO, 16'h0000, 0, 16'h4001, 0, 0, 0, 1, 1);
        add(OP_C1,  16'h0001, 1, 16'h0001, 0, 0, 0, 1, 0);
        add(OP_C2,  16'h0021, 1, 16'h0021, 0, 0, 0, 1, 0);
        add(OP_C1,  16'h0021, 1, 16'h0021, 0, 0, 0, 1, 0);
        add(OP_C2,  16'h0021, 1, 16'h0021, 1, 0, 0, 1, 0);
        add(OP_EHI, 16'h1234, 0, 16'h0021, 0, 0, 0, 1, 1);
        add(OP_C2,  16'h1234, 1, 16'h1234, 0, 0, 0, 1, 0);
        add(OP_I1,  16'h0000, 0, 16'h1234, 0, 0, 0, 1, 0);
        add(OP_I1,  16'h0000, 0, 16'h1234, 0, 0, 0, 1, 0);
        add(OP_I1,  16'h0000, 0, 16'h1234, 0, 0, 1, 0, 0);
        add(OP_KLO, 16'h0000, 0, 16'h1234, 0, 0, 0, 0, 1);
        add(OP_I1,  16'h0000, 0, 16'h1234, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            send_op(tbl[i].op, tbl[i].word, 1'b0);
            check_exp($sformatf("vec%0d", i), tbl[i].v, tbl[i].w, tbl[i].ab, tbl[i].ack,
                      tbl[i].idle, tbl[i].seen, tbl[i].err);
        end

        // Stalled stream: every byte preceded by an idle cycle
        do_reset("pre_stall");
        send_op(OP_C1, 16'h01A0, 1'b1);
        check_exp("stall1", 1'b1, 16'h01A0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_op(OP_C1, 16'h01A0, 1'b1);
        check_exp("stall2", 1'b1, 16'h01A0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_op(OP_C1, 16'h01A0, 1'b1);
        check_exp("stall3", 1'b1, 16'h01A0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a set discards the partial word
        put(8'hBC, 1'b1, 1'b0, 1'b0);
        put(8'hB5, 1'b0, 1'b0, 1'b0);
        put(8'h77, 1'b0, 1'b0, 1'b0);
        do_reset("midset_reset");
        put(8'h41, 1'b0, 1'b0, 1'b0);
        check_exp("after_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic in short bursts of one kind of set
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            reps = $urandom_range(1, 4);
            for (int j = 0; j < reps; j++) begin
                if (r <= 4)      op = ($urandom_range(0, 1) == 0) ? OP_C1 : OP_C2;
                else if (r <= 7) op = ($urandom_range(0, 1) == 0) ? OP_I1 : OP_I2;
                else if (r == 8) op = OP_KLO;
                else             op = OP_EHI;
                if ($urandom_range(0, 7) == 0) w = 16'($urandom);
                else                           w = pool[$urandom_range(0, 3)];
                send_op(op, w, ($urandom_range(0, 3) == 0));
                check_exp("rand", m_v, m_word, model_ab(), model_ab() & m_word[14],
                          (idle_n >= MC), m_seen, m_err);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sgmii_an_config_rx.md
Name: sgmii_an_config_rx

Overview:
- Receive-side ordered-set parser for SGMII / 1000BASE-X Clause 37 auto-negotiation.
- Consumes the decoded 8b/10b byte stream from the SGMII deserializer/decoder.
- Recognises /C1/, /C2/, /I1/ and /I2/ ordered sets, extracts the 16-bit link-partner config word, and qualifies it with ability, acknowledge and idle match flags.
- Its outputs feed the auto-negotiation arbitration FSM, and eth_status bits are driven from them. In loopback it checks the local config transmitter end-to-end.

Parameters:
- MATCH_COUNT, 3, consecutive identical ordered sets required before ability_match or idle_match asserts (range 2..7).
- CNT_W, 3, width of the match counters; must satisfy 2^CNT_W > MATCH_COUNT.

Ports:
- clock  in  1  sgmii_clk domain, 125 MHz
- reset  in  1  synchronous, active-high
- rx_valid  in  1  byte strobe; when low the block holds all state
- rx_data  in  8  decoded byte
- rx_is_k  in  1  rx_data is a K character
- rx_code_err  in  1  disparity or invalid-code error on this byte
- cfg_word  out  16  last received config word, low byte first on the wire
- cfg_valid  out  1  one-cycle pulse per complete /C/ set
- ability_match  out  1  MATCH_COUNT consecutive equal words, bit 14 (ACK) ignored in the compare
- ack_match  out  1  ability_match and cfg_word[14]=1
- idle_match  out  1  MATCH_COUNT consecutive /I/ sets
- config_seen  out  1  sticky; set by the first valid /C/, cleared by reset or by idle_match
- rx_err  out  1  one-cycle pulse on a protocol or code error

Behaviour:
- Reset values: all outputs 0; FSM in HUNT; both counters 0; previous-word register 0.
- Symbol constants: K28.5=0xBC, D21.5=0xB5 (C1), D2.2=0x42 (C2), D5.6=0xC5 (I1), D16.2=0x50 (I2).
- A byte is accepted only when rx_valid=1.
- FSM states:
  - HUNT: on accepted K28.5 -> COMMA; any other byte stays in HUNT with no error.
  - COMMA: next byte must be a D character.
    - 0xB5 or 0x42 -> CFG_LO.
    - 0xC5 or 0x50 -> HUNT, counting one idle set.
    - Anything else -> HUNT with rx_err.
  - CFG_LO: latch the D byte as word[7:0] -> CFG_HI.
  - CFG_HI: latch the D byte as word[15:8]; pulse cfg_valid and update cfg_word the next cycle (latency 1 after the high byte); -> HUNT.
- Error abort: a K character in CFG_LO/CFG_HI, or rx_code_err in any non-HUNT state -> HUNT, rx_err pulse.
  - On abort, reset the config counter and idle counter to 0, and clear ability_match, ack_match and idle_match.
  - cfg_word and config_seen hold.
- rx_code_err in HUNT: rx_err pulse and counters reset; the FSM stays in HUNT.
- Config match counting: on each complete word, compare {new[15], new[13:0]} with the same bits of the previous word.
  - Equal: counter +1, saturating at MATCH_COUNT.
  - Not equal: counter reloads to 1.
  - Idle counter resets to 0.
- ability_match = (config counter == MATCH_COUNT). It updates in the same cycle as the cfg_valid pulse.
- ack_match = ability_match & cfg_word[14]. A word differing only in ACK does not break the match; ack_match follows the latest word.
- Idle counting: each idle set increments the idle counter (saturating), and resets the config counter and ability_match.
  - idle_match asserts when the idle counter reaches MATCH_COUNT, in the cycle after the D5.6/D16.2 byte.
  - idle_match also clears config_seen.
- Simultaneous events: a single byte stream cannot produce these; a stall (rx_valid=0) in mid-set is allowed and the FSM waits indefinitely.
- Reset mid-set discards the partial word.

Decomposition:
- Package sgmii_an_pkg holds:
  - K/D symbol localparams;
  - rx FSM state enum {HUNT, COMMA, CFG_LO, CFG_HI};
  - config-word bit-field constants: ACK=14, NP=15, SGMII link/speed/duplex fields. These are shared with the transmitter.
- One sub-module, sgmii_an_match_cnt: a saturating match counter with equal/not-equal/clear inputs. It is instantiated twice (config and idle).

Test Plan:
- Three /C1/,/C2/,/C1/ sets carrying 0x4001 -> three cfg_valid pulses; ability_match=1 after the third; ack_match=1; cfg_word=0x4001.
- Words 0x0001,0x0001,0x4001 -> ability_match=1 at the third word (ACK ignored); ack_match=1 only at the third.
- Words 0x0001,0x0021,0x0021 -> ability_match stays 0; a fourth 0x0021 -> 1.
- Three /I2/ sets after config -> ability_match drops at the first idle; idle_match=1 after the third; config_seen=0.
- K28.5 inside CFG_LO, or rx_code_err on the high byte -> rx_err pulse, no cfg_valid, counters cleared, cfg_word unchanged.
- rx_valid toggled 0/1 every other cycle across three 0x01A0 sets -> results identical to the unstalled case; reset asserted mid-set -> all outputs 0 the next cycle.
